e203_soc_padctl: RTL and testbench
==================================

// Module: e203_soc_padctl
// PURPOSE
// - Pad-control and always-on glue slice of the E203 SoC top. Sits between the chip pads and the
//   subsystem, alongside the CPU subsystem.
// - Provides GPIO A/B output, output-enable and input registers, an RTC tick counter driven by
//   lfextclk, boot/debug-mode strap capture, PMU pad controls and the reset-vector select.
// - All registers are reachable over a single-beat ICB-style register port.
// PARAMETERS
// - ROM_VEC    32'h0000_1000  reset vector when io_pads_bootrom_n_i_ival=0 (boot from ROM)
// - FLASH_VEC  32'h2000_0000  reset vector when io_pads_bootrom_n_i_ival=1
// PORTS
// - hfextclk                     in   1   sole clock; all logic on its rising edge
// - rst                          in   1   reset, synchronous, active-high
// - icb_cmd_valid/icb_cmd_ready  in/out 1  command handshake
// - icb_cmd_read                 in   1   1=read, 0=write
// - icb_cmd_addr                 in   12  byte address (bits[1:0] ignored)
// - icb_cmd_wdata                in   32  write data (full-word writes only)
// - icb_rsp_valid/icb_rsp_ready  out/in 1 response handshake
// - icb_rsp_rdata                out  32  read data (0 for writes and errors)
// - icb_rsp_err                  out  1   unmapped address or write to RO reg
// - lfextclk                     in   1   slow clock, treated as data and sampled in hfextclk
// - io_pads_gpioA_i_ival/gpioB_i_ival   in  32  GPIO pad inputs
// - io_pads_gpioA_o_oval/_o_oe, gpioB_o_oval/_o_oe  out 32  GPIO out value / enable
// - io_pads_bootrom_n_i_ival     in   1   boot strap
// - io_pads_dbgmode0/1/2_n_i_ival in  1   debug-mode straps
// - io_pads_aon_pmu_dwakeup_n_i_ival in 1 wakeup pad, active-low
// - io_pads_aon_pmu_vddpaden_o_oval, io_pads_aon_pmu_padrst_o_oval  out 1  PMU pads
// - hfxoscen, lfxoscen           out  1   oscillator enables
// - reset_vector                 out  32  PC the core boots from
// - wakeup_irq                   out  1   level, set by a wakeup event
// BEHAVIOUR
// - Register map (word offsets):
//   - 0x00 GPIOA_IN RO; 0x04 GPIOA_OUT RW; 0x08 GPIOA_OE RW
//   - 0x0C GPIOB_IN RO; 0x10 GPIOB_OUT RW; 0x14 GPIOB_OE RW
//   - 0x18 RTC_CNT RW (write loads the value)
//   - 0x1C STRAP RO: [0]=bootrom_n, [3:1]=dbgmode2..0_n
//   - 0x20 PMU RW: [0]vddpaden [1]padrst [2]hfxoscen [3]lfxoscen
//   - 0x24 WAKE W1C: [0]=wakeup flag
// - Reset values:
//   - All OUT and OE registers 0; RTC_CNT 0; PMU = 4'b1101; WAKE 0.
//   - icb_rsp_valid 0; icb_rsp_rdata 0; icb_rsp_err 0.
// - GPIO inputs use 2-flop synchronizers, so a read returns the pad value from 2+ cycles earlier.
//   Outputs drive straight from the registers.
// - lfextclk goes through a 2-flop synchronizer plus an edge register. Each detected rising edge
//   increments RTC_CNT by 1, wrapping 32'hFFFF_FFFF -> 0. A CPU write in the same cycle wins over
//   the increment.
// - Straps are captured on every cycle with rst=1 and frozen while rst=0.
//   reset_vector = bootrom_n ? FLASH_VEC : ROM_VEC, using the captured strap.
// - dwakeup_n passes through a 2-flop synchronizer. A synchronized 1->0 edge sets WAKE[0].
//   wakeup_irq = WAKE[0]. If a set and a W1C land in the same cycle, the set wins.
// - ICB handshake:
//   - icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready.
//   - A command accepted in cycle N gives icb_rsp_valid=1 in cycle N+1. The write takes effect
//     at the end of cycle N.
//   - The response holds stable until icb_rsp_ready=1; that allows back-to-back commands at
//     1 per cycle.
// - Error cases: unmapped offset, or a write to a RO register, returns rsp_err=1 and rdata=0.
//   No register changes.
// - Asserting rst mid-transaction drops any pending response and restores all reset values on the
//   next edge.
// TESTING
// - Reset, then read each register -> GPIO OUT/OE = 0, PMU = 0xD, RTC = 0, err = 0.
//   Also vddpaden=1, hfxoscen=1, lfxoscen=1.
// - Write 0xA5A5_0F0F to 0x04 and 0xFFFF_0000 to 0x08 -> gpioA_o_oval = 0xA5A5_0F0F,
//   gpioA_o_oe = 0xFFFF_0000, readback matches.
// - Drive gpioB_i = 0x1234_5678, wait 3 cycles, read 0x0C -> 0x1234_5678.
// - Toggle lfextclk every 33 hfextclk edges for 10 periods -> RTC_CNT = 10.
//   Write 0xFFFF_FFFF, give one more edge -> 0.
// - Hold bootrom_n=0 during reset -> reset_vector = 0x0000_1000.
//   Change the strap after reset -> unchanged. Reset with bootrom_n=1 -> 0x2000_0000.
// - Read 0x40 -> err = 1, rdata = 0. Write 0x00 -> err = 1.
//   Pull dwakeup_n low -> wakeup_irq = 1. Write 1 to 0x24 -> 0.
//   Hold rsp_ready = 0 for 3 cycles -> rsp stays stable and cmd_ready = 0.

Source files
------------

// File: rtl/e203_soc_padctl.sv
// ---------------------------------------------------------------------------
// e203_soc_padctl
//
// Pad-control and always-on glue slice of the E203 SoC top. It holds the
// GPIO A/B output, output-enable and synchronized input registers. It also
// holds an RTC tick counter clocked by edges of lfextclk, the boot/debug
// strap capture, the PMU pad controls, the wakeup flag and the reset-vector
// select. Every register is reachable over a single-beat ICB-style register
// port.
//
// Ports
//   hfextclk, rst              sole clock (rising edge), synchronous
//                              active-high reset
//   icb_cmd_*                  command channel: valid/ready, read,
//                              12-bit byte address, 32-bit write data
//   icb_rsp_*                  response channel: valid/ready, rdata, err
//   lfextclk                   slow clock, sampled as data
//   io_pads_gpio{A,B}_i_ival   GPIO pad inputs
//   io_pads_gpio{A,B}_o_*      GPIO output value / output enable
//   io_pads_bootrom_n_i_ival,
//   io_pads_dbgmode{0,1,2}_n_* boot / debug straps
//   io_pads_aon_pmu_*          wakeup pad input, vddpaden / padrst pads
//   hfxoscen, lfxoscen         oscillator enables
//   reset_vector               core boot PC chosen by the captured strap
//   wakeup_irq                 level interrupt mirroring WAKE[0]
//
// Register map (word offsets): 0x00 GPIOA_IN RO, 0x04 GPIOA_OUT, 0x08 GPIOA_OE,
// 0x0C GPIOB_IN RO, 0x10 GPIOB_OUT, 0x14 GPIOB_OE, 0x18 RTC_CNT, 0x1C STRAP RO,
// 0x20 PMU, 0x24 WAKE (write-1-to-clear).
// ---------------------------------------------------------------------------
module e203_soc_padctl #(
  parameter logic [31:0] ROM_VEC   = 32'h0000_1000,
  parameter logic [31:0] FLASH_VEC = 32'h2000_0000
) (
  input  logic        hfextclk,
  input  logic        rst,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic        icb_cmd_read,
  input  logic [11:0] icb_cmd_addr,
  input  logic [31:0] icb_cmd_wdata,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  input  logic        lfextclk,
  input  logic [31:0] io_pads_gpioA_i_ival,
  input  logic [31:0] io_pads_gpioB_i_ival,
  output logic [31:0] io_pads_gpioA_o_oval,
  output logic [31:0] io_pads_gpioA_o_oe,
  output logic [31:0] io_pads_gpioB_o_oval,
  output logic [31:0] io_pads_gpioB_o_oe,
  input  logic        io_pads_bootrom_n_i_ival,
  input  logic        io_pads_dbgmode0_n_i_ival,
  input  logic        io_pads_dbgmode1_n_i_ival,
  input  logic        io_pads_dbgmode2_n_i_ival,
  input  logic        io_pads_aon_pmu_dwakeup_n_i_ival,
  output logic        io_pads_aon_pmu_vddpaden_o_oval,
  output logic        io_pads_aon_pmu_padrst_o_oval,
  output logic        hfxoscen,
  output logic        lfxoscen,
  output logic [31:0] reset_vector,
  output logic        wakeup_irq
);

  localparam logic [9:0] IDX_GPIOA_IN  = 10'd0;
  localparam logic [9:0] IDX_GPIOA_OUT = 10'd1;
  localparam logic [9:0] IDX_GPIOA_OE  = 10'd2;
  localparam logic [9:0] IDX_GPIOB_IN  = 10'd3;
  localparam logic [9:0] IDX_GPIOB_OUT = 10'd4;
  localparam logic [9:0] IDX_GPIOB_OE  = 10'd5;
  localparam logic [9:0] IDX_RTC_CNT   = 10'd6;
  localparam logic [9:0] IDX_STRAP     = 10'd7;
  localparam logic [9:0] IDX_PMU       = 10'd8;
  localparam logic [9:0] IDX_WAKE      = 10'd9;

  // PMU bits: [0] vddpaden, [1] padrst, [2] hfxoscen, [3] lfxoscen
  localparam logic [3:0] PMU_RESET = 4'b1101;

  logic [31:0] gpioa_out_q, gpioa_out_d;
  logic [31:0] gpioa_oe_q,  gpioa_oe_d;
  logic [31:0] gpiob_out_q, gpiob_out_d;
  logic [31:0] gpiob_oe_q,  gpiob_oe_d;
  logic [31:0] rtc_cnt_q,   rtc_cnt_d;
  logic [3:0]  pmu_q,       pmu_d;
  logic        wake_q,      wake_d;
  logic [3:0]  strap_q,     strap_d;

  logic [31:0] gpioa_s1_q, gpioa_s1_d, gpioa_s2_q, gpioa_s2_d;
  logic [31:0] gpiob_s1_q, gpiob_s1_d, gpiob_s2_q, gpiob_s2_d;
  logic        lf_s1_q, lf_s1_d, lf_s2_q, lf_s2_d, lf_prev_q, lf_prev_d;
  logic        dw_s1_q, dw_s1_d, dw_s2_q, dw_s2_d, dw_prev_q, dw_prev_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;

  logic [9:0]  word_idx;
  logic        mapped;
  logic        read_only;
  logic [31:0] rd_mux;
  logic        cmd_err;
  logic        cmd_fire;
  logic        wr_en;
  logic        lf_rise;
  logic        dw_fall;

  // A new command is taken whenever the response slot is empty or is being
  // drained this cycle, which gives one command per cycle under no backpressure.
  assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;

  // Address decode and read mux. The low two address bits are ignored.
  // Writes to read-only registers are reported as errors.
  always_comb begin
    word_idx  = icb_cmd_addr[11:2];
    mapped    = 1'b1;
    read_only = 1'b0;
    rd_mux    = 32'd0;
    case (word_idx)
      IDX_GPIOA_IN:  begin read_only = 1'b1; rd_mux = gpioa_s2_q; end
      IDX_GPIOA_OUT: rd_mux = gpioa_out_q;
      IDX_GPIOA_OE:  rd_mux = gpioa_oe_q;
      IDX_GPIOB_IN:  begin read_only = 1'b1; rd_mux = gpiob_s2_q; end
      IDX_GPIOB_OUT: rd_mux = gpiob_out_q;
      IDX_GPIOB_OE:  rd_mux = gpiob_oe_q;
      IDX_RTC_CNT:   rd_mux = rtc_cnt_q;
      IDX_STRAP:     begin read_only = 1'b1; rd_mux = {28'd0, strap_q}; end
      IDX_PMU:       rd_mux = {28'd0, pmu_q};
      IDX_WAKE:      rd_mux = {31'd0, wake_q};
      default:       mapped = 1'b0;
    endcase
    cmd_err  = ~mapped | (~icb_cmd_read & read_only);
    cmd_fire = icb_cmd_valid & icb_cmd_ready;
    wr_en    = cmd_fire & ~icb_cmd_read & ~cmd_err;
  end

  // Next-state logic for registers, synchronizers and the response slot.
  always_comb begin
    gpioa_out_d = gpioa_out_q;
    gpioa_oe_d  = gpioa_oe_q;
    gpiob_out_d = gpiob_out_q;
    gpiob_oe_d  = gpiob_oe_q;
    rtc_cnt_d   = rtc_cnt_q;
    pmu_d       = pmu_q;
    wake_d      = wake_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    gpioa_s1_d = io_pads_gpioA_i_ival;
    gpioa_s2_d = gpioa_s1_q;
    gpiob_s1_d = io_pads_gpioB_i_ival;
    gpiob_s2_d = gpiob_s1_q;
    lf_s1_d    = lfextclk;
    lf_s2_d    = lf_s1_q;
    lf_prev_d  = lf_s2_q;
    dw_s1_d    = io_pads_aon_pmu_dwakeup_n_i_ival;
    dw_s2_d    = dw_s1_q;
    dw_prev_d  = dw_s2_q;

    // Straps follow the pads while reset is held and freeze afterwards.
    strap_d = rst ? {io_pads_dbgmode2_n_i_ival, io_pads_dbgmode1_n_i_ival,
                     io_pads_dbgmode0_n_i_ival, io_pads_bootrom_n_i_ival}
                  : strap_q;

    lf_rise = lf_s2_q & ~lf_prev_q;
    dw_fall = dw_prev_q & ~dw_s2_q;

    if (wr_en && word_idx == IDX_GPIOA_OUT) gpioa_out_d = icb_cmd_wdata;
    if (wr_en && word_idx == IDX_GPIOA_OE)  gpioa_oe_d  = icb_cmd_wdata;
    if (wr_en && word_idx == IDX_GPIOB_OUT) gpiob_out_d = icb_cmd_wdata;
    if (wr_en && word_idx == IDX_GPIOB_OE)  gpiob_oe_d  = icb_cmd_wdata;
    if (wr_en && word_idx == IDX_PMU)       pmu_d       = icb_cmd_wdata[3:0];

    // A CPU load of the counter takes priority over a tick in the same cycle.
    if (wr_en && word_idx == IDX_RTC_CNT) begin
      rtc_cnt_d = icb_cmd_wdata;
    end else if (lf_rise) begin
      rtc_cnt_d = rtc_cnt_q + 32'd1;
    end

    // A fresh wakeup event must not be lost to a concurrent clear.
    if (dw_fall) begin
      wake_d = 1'b1;
    end else if (wr_en && word_idx == IDX_WAKE && icb_cmd_wdata[0]) begin
      wake_d = 1'b0;
    end

    // Response slot: load on accept, otherwise empty it once consumed.
    if (cmd_fire) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cmd_err;
      rsp_rdata_d = (icb_cmd_read && !cmd_err) ? rd_mux : 32'd0;
    end else if (icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State register. Sync chains reset to the idle pad levels so that no
  // spurious tick or wakeup edge appears right after reset.
  always_ff @(posedge hfextclk) begin
    if (rst) begin
      gpioa_out_q <= 32'd0;
      gpioa_oe_q  <= 32'd0;
      gpiob_out_q <= 32'd0;
      gpiob_oe_q  <= 32'd0;
      rtc_cnt_q   <= 32'd0;
      pmu_q       <= PMU_RESET;
      wake_q      <= 1'b0;
      gpioa_s1_q  <= 32'd0;
      gpioa_s2_q  <= 32'd0;
      gpiob_s1_q  <= 32'd0;
      gpiob_s2_q  <= 32'd0;
      lf_s1_q     <= 1'b0;
      lf_s2_q     <= 1'b0;
      lf_prev_q   <= 1'b0;
      dw_s1_q     <= 1'b1;
      dw_s2_q     <= 1'b1;
      dw_prev_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      gpioa_out_q <= gpioa_out_d;
      gpioa_oe_q  <= gpioa_oe_d;
      gpiob_out_q <= gpiob_out_d;
      gpiob_oe_q  <= gpiob_oe_d;
      rtc_cnt_q   <= rtc_cnt_d;
      pmu_q       <= pmu_d;
      wake_q      <= wake_d;
      gpioa_s1_q  <= gpioa_s1_d;
      gpioa_s2_q  <= gpioa_s2_d;
      gpiob_s1_q  <= gpiob_s1_d;
      gpiob_s2_q  <= gpiob_s2_d;
      lf_s1_q     <= lf_s1_d;
      lf_s2_q     <= lf_s2_d;
      lf_prev_q   <= lf_prev_d;
      dw_s1_q     <= dw_s1_d;
      dw_s2_q     <= dw_s2_d;
      dw_prev_q   <= dw_prev_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
    strap_q <= strap_d;
  end

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign icb_rsp_err   = rsp_err_q;

  assign io_pads_gpioA_o_oval = gpioa_out_q;
  assign io_pads_gpioA_o_oe   = gpioa_oe_q;
  assign io_pads_gpioB_o_oval = gpiob_out_q;
  assign io_pads_gpioB_o_oe   = gpiob_oe_q;

  assign io_pads_aon_pmu_vddpaden_o_oval = pmu_q[0];
  assign io_pads_aon_pmu_padrst_o_oval   = pmu_q[1];
  assign hfxoscen                        = pmu_q[2];
  assign lfxoscen                        = pmu_q[3];

  assign reset_vector = strap_q[0] ? FLASH_VEC : ROM_VEC;
  assign wakeup_irq   = wake_q;

endmodule

// File: tb/tb_e203_soc_padctl.sv
// ---------------------------------------------------------------------------
// tb_e203_soc_padctl
//
// Self-checking bench for e203_soc_padctl. Register transactions push the
// expected response into a scoreboard queue when they are issued. A monitor
// pops and compares every response that the DUT hands over. Pad outputs are
// compared directly. The main register walk is a table of vectors, followed
// by hand-written sequences for the multi-cycle corners: synchronizer delay,
// RTC ticks and wrap, strap freeze, wakeup and clear, backpressure, and reset
// mid-transaction.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_e203_soc_padctl;

  logic        hfextclk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [11:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        lfextclk;
  logic [31:0] gpioa_i, gpiob_i;
  logic [31:0] gpioa_oval, gpioa_oe, gpiob_oval, gpiob_oe;
  logic        bootrom_n, dbg0_n, dbg1_n, dbg2_n, dwakeup_n;
  logic        vddpaden, padrst, hfxoscen, lfxoscen;
  logic [31:0] reset_vector;
  logic        wakeup_irq;

  e203_soc_padctl dut (
    .hfextclk                         (hfextclk),
    .rst                              (rst),
    .icb_cmd_valid                    (icb_cmd_valid),
    .icb_cmd_ready                    (icb_cmd_ready),
    .icb_cmd_read                     (icb_cmd_read),
    .icb_cmd_addr                     (icb_cmd_addr),
    .icb_cmd_wdata                    (icb_cmd_wdata),
    .icb_rsp_valid                    (icb_rsp_valid),
    .icb_rsp_ready                    (icb_rsp_ready),
    .icb_rsp_rdata                    (icb_rsp_rdata),
    .icb_rsp_err                      (icb_rsp_err),
    .lfextclk                         (lfextclk),
    .io_pads_gpioA_i_ival             (gpioa_i),
    .io_pads_gpioB_i_ival             (gpiob_i),
    .io_pads_gpioA_o_oval             (gpioa_oval),
    .io_pads_gpioA_o_oe               (gpioa_oe),
    .io_pads_gpioB_o_oval             (gpiob_oval),
    .io_pads_gpioB_o_oe               (gpiob_oe),
    .io_pads_bootrom_n_i_ival         (bootrom_n),
    .io_pads_dbgmode0_n_i_ival        (dbg0_n),
    .io_pads_dbgmode1_n_i_ival        (dbg1_n),
    .io_pads_dbgmode2_n_i_ival        (dbg2_n),
    .io_pads_aon_pmu_dwakeup_n_i_ival (dwakeup_n),
    .io_pads_aon_pmu_vddpaden_o_oval  (vddpaden),
    .io_pads_aon_pmu_padrst_o_oval    (padrst),
    .hfxoscen                         (hfxoscen),
    .lfxoscen                         (lfxoscen),
    .reset_vector                     (reset_vector),
    .wakeup_irq                       (wakeup_irq)
  );

  always #5 hfextclk = ~hfextclk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    bit          rd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input bit rd, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.rd = rd; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge hfextclk);
    #1;
  endtask

  // Issue one command at the falling edge, record its expected response, and
  // drop valid just after it is accepted.
  task automatic applyStimulus(input bit rd, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input bit exp_err);
    exp_t e;
    int   waited;
    @(negedge hfextclk);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = addr;
    icb_cmd_wdata = wdata;
    e.addr  = addr;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    waited  = 0;
    #1;
    while (!icb_cmd_ready && waited < 20) begin
      @(negedge hfextclk);
      #1;
      waited++;
    end
    if (!icb_cmd_ready) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL cmd_accept@0x%03h: cmd_ready stayed 0, expected 1", addr);
      icb_cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge hfextclk);
    #1;
    icb_cmd_valid = 1'b0;
  endtask

  // Wait a bounded time for all expected responses to be consumed.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge hfextclk);
      #2;
      n++;
    end
    checkOutput("scoreboard_drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: a response is handed over at the next rising edge
  // whenever valid and ready are both high at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge hfextclk);
      #1;
      if (icb_rsp_valid === 1'b1 && icb_rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response",
                   icb_rsp_rdata, icb_rsp_err);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("rsp_rdata@0x%03h", e.addr), icb_rsp_rdata, e.rdata);
          checkOutput($sformatf("rsp_err@0x%03h", e.addr), {31'd0, icb_rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = 12'h000;
    icb_cmd_wdata = 32'd0;
    icb_rsp_ready = 1'b1;
    lfextclk      = 1'b0;
    gpioa_i       = 32'hCAFE_F00D;
    gpiob_i       = 32'd0;
    bootrom_n     = 1'b0;
    dbg0_n        = 1'b1;
    dbg1_n        = 1'b0;
    dbg2_n        = 1'b1;
    dwakeup_n     = 1'b1;

    waitCycles(5);
    @(negedge hfextclk);
    rst = 1'b0;
    @(negedge hfextclk);
    #2;
    $display("[TB] reset state");
    checkOutput("rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, icb_rsp_err}, 32'd0);
    checkOutput("rst_gpioa_oval", gpioa_oval, 32'd0);
    checkOutput("rst_gpioa_oe", gpioa_oe, 32'd0);
    checkOutput("rst_gpiob_oval", gpiob_oval, 32'd0);
    checkOutput("rst_gpiob_oe", gpiob_oe, 32'd0);
    checkOutput("rst_pmu_pads", {28'd0, lfxoscen, hfxoscen, padrst, vddpaden}, 32'hD);
    checkOutput("rst_reset_vector", reset_vector, 32'h0000_1000);
    checkOutput("rst_wakeup_irq", {31'd0, wakeup_irq}, 32'd0);

    // Register walk: reset values, GPIO A writes, error cases, GPIO B and PMU.
    addVec(1, 12'h004, 0, 32'h0000_0000, 0);
    addVec(1, 12'h008, 0, 32'h0000_0000, 0);
    addVec(1, 12'h010, 0, 32'h0000_0000, 0);
    addVec(1, 12'h014, 0, 32'h0000_0000, 0);
    addVec(1, 12'h018, 0, 32'h0000_0000, 0);
    addVec(1, 12'h020, 0, 32'h0000_000D, 0);
    addVec(1, 12'h024, 0, 32'h0000_0000, 0);
    addVec(1, 12'h01C, 0, 32'h0000_000A, 0);
    addVec(1, 12'h000, 0, 32'hCAFE_F00D, 0);
    addVec(0, 12'h004, 32'hA5A5_0F0F, 32'h0, 0);
    addVec(0, 12'h008, 32'hFFFF_0000, 32'h0, 0);
    addVec(1, 12'h004, 0, 32'hA5A5_0F0F, 0);
    addVec(1, 12'h008, 0, 32'hFFFF_0000, 0);
    addVec(1, 12'h005, 0, 32'hA5A5_0F0F, 0);
    addVec(1, 12'h040, 0, 32'h0000_0000, 1);
    addVec(0, 12'h000, 32'hDEAD_BEEF, 32'h0, 1);
    addVec(1, 12'h000, 0, 32'hCAFE_F00D, 0);
    addVec(0, 12'h00C, 32'h1111_2222, 32'h0, 1);
    addVec(0, 12'h01C, 32'hFFFF_FFFF, 32'h0, 1);
    addVec(1, 12'h028, 0, 32'h0000_0000, 1);
    addVec(0, 12'h3FC, 32'h1234_5678, 32'h0, 1);
    addVec(1, 12'h01C, 0, 32'h0000_000A, 0);
    addVec(0, 12'h010, 32'h1357_9BDF, 32'h0, 0);
    addVec(0, 12'h014, 32'h0000_FFFF, 32'h0, 0);
    addVec(1, 12'h010, 0, 32'h1357_9BDF, 0);
    addVec(1, 12'h014, 0, 32'h0000_FFFF, 0);
    addVec(0, 12'h020, 32'h0000_0006, 32'h0, 0);
    addVec(1, 12'h020, 0, 32'h0000_0006, 0);

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i])
      applyStimulus(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    drain();
    checkOutput("gpioa_oval", gpioa_oval, 32'hA5A5_0F0F);
    checkOutput("gpioa_oe", gpioa_oe, 32'hFFFF_0000);
    checkOutput("gpiob_oval", gpiob_oval, 32'h1357_9BDF);
    checkOutput("gpiob_oe", gpiob_oe, 32'h0000_FFFF);
    checkOutput("pmu_pads", {28'd0, lfxoscen, hfxoscen, padrst, vddpaden}, 32'h6);

    $display("[TB] GPIO B input synchronizer");
    gpiob_i = 32'h1234_5678;
    waitCycles(3);
    applyStimulus(1, 12'h00C, 0, 32'h1234_5678, 0);

    $display("[TB] RTC ticks, wrap and write priority");
    for (int p = 0; p < 10; p++) begin
      waitCycles(33);
      lfextclk = 1'b1;
      waitCycles(33);
      lfextclk = 1'b0;
    end
    waitCycles(5);
    applyStimulus(1, 12'h018, 0, 32'd10, 0);
    applyStimulus(0, 12'h018, 32'hFFFF_FFFF, 32'h0, 0);
    applyStimulus(1, 12'h018, 0, 32'hFFFF_FFFF, 0);
    lfextclk = 1'b1;
    waitCycles(5);
    applyStimulus(1, 12'h018, 0, 32'h0000_0000, 0);
    lfextclk = 1'b0;
    waitCycles(5);
    @(posedge hfextclk);
    #1;
    lfextclk = 1'b1;
    @(posedge hfextclk);
    @(posedge hfextclk);
    applyStimulus(0, 12'h018, 32'h0000_0055, 32'h0, 0);
    waitCycles(3);
    applyStimulus(1, 12'h018, 0, 32'h0000_0055, 0);
    lfextclk = 1'b0;
    drain();

    $display("[TB] strap freeze");
    bootrom_n = 1'b1;
    dbg0_n    = 1'b0;
    waitCycles(5);
    checkOutput("strap_frozen_vector", reset_vector, 32'h0000_1000);
    applyStimulus(1, 12'h01C, 0, 32'h0000_000A, 0);
    dbg0_n = 1'b1;

    $display("[TB] wakeup set and clear");
    dwakeup_n = 1'b0;
    waitCycles(5);
    checkOutput("wakeup_irq_set", {31'd0, wakeup_irq}, 32'd1);
    applyStimulus(1, 12'h024, 0, 32'h1, 0);
    applyStimulus(0, 12'h024, 32'h0, 32'h0, 0);
    checkOutput("wakeup_w0_keeps", {31'd0, wakeup_irq}, 32'd1);
    applyStimulus(0, 12'h024, 32'h1, 32'h0, 0);
    checkOutput("wakeup_w1c", {31'd0, wakeup_irq}, 32'd0);
    dwakeup_n = 1'b1;
    waitCycles(5);
    checkOutput("wakeup_rise_ignored", {31'd0, wakeup_irq}, 32'd0);
    @(posedge hfextclk);
    #1;
    dwakeup_n = 1'b0;
    @(posedge hfextclk);
    @(posedge hfextclk);
    applyStimulus(0, 12'h024, 32'h1, 32'h0, 0);
    checkOutput("wakeup_set_beats_clear", {31'd0, wakeup_irq}, 32'd1);
    applyStimulus(0, 12'h024, 32'h1, 32'h0, 0);
    applyStimulus(1, 12'h024, 0, 32'h0, 0);
    dwakeup_n = 1'b1;
    waitCycles(4);
    drain();

    $display("[TB] response backpressure");
    @(negedge hfextclk);
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 12'h004;
    exp_q.push_back('{12'h004, 32'hA5A5_0F0F, 1'b0});
    @(posedge hfextclk);
    #1;
    icb_cmd_addr = 12'h008;
    exp_q.push_back('{12'h008, 32'hFFFF_0000, 1'b0});
    for (int c = 0; c < 3; c++) begin
      @(negedge hfextclk);
      #2;
      checkOutput("stall_rsp_valid", {31'd0, icb_rsp_valid}, 32'd1);
      checkOutput("stall_rsp_rdata", icb_rsp_rdata, 32'hA5A5_0F0F);
      checkOutput("stall_cmd_ready", {31'd0, icb_cmd_ready}, 32'd0);
    end
    @(negedge hfextclk);
    icb_rsp_ready = 1'b1;
    @(posedge hfextclk);
    #1;
    icb_cmd_valid = 1'b0;
    drain();

    $display("[TB] reset during pending response");
    @(negedge hfextclk);
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = 12'h004;
    icb_cmd_wdata = 32'h1111_1111;
    @(posedge hfextclk);
    #1;
    icb_cmd_valid = 1'b0;
    checkOutput("pending_write_applied", gpioa_oval, 32'h1111_1111);
    checkOutput("pending_rsp_valid", {31'd0, icb_rsp_valid}, 32'd1);
    rst = 1'b1;
    @(posedge hfextclk);
    #1;
    checkOutput("midrst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
    checkOutput("midrst_gpioa_oval", gpioa_oval, 32'd0);
    checkOutput("midrst_pmu_pads", {28'd0, lfxoscen, hfxoscen, padrst, vddpaden}, 32'hD);
    checkOutput("midrst_reset_vector", reset_vector, 32'h2000_0000);
    waitCycles(2);
    @(negedge hfextclk);
    rst           = 1'b0;
    icb_rsp_ready = 1'b1;
    applyStimulus(1, 12'h01C, 0, 32'h0000_000B, 0);
    applyStimulus(1, 12'h004, 0, 32'h0000_0000, 0);
    applyStimulus(1, 12'h020, 0, 32'h0000_000D, 0);
    drain();
    checkOutput("final_reset_vector", reset_vector, 32'h2000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
